// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
// Bundles the CPU writeback ports, the VPU scalar-write handshake and the
// register-file write ports plus status outputs of regfile_write_arbiter.
// slave  : seen by the arbiter (drives rf_*, status, vpu_wr_ready)
// master : seen by the environment (drives CPU and VPU requests)

interface regfile_write_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // CPU writeback stage
  logic             cpu_we_0;
  logic             cpu_we_1;
  logic [4:0]       cpu_addr_0;
  logic [4:0]       cpu_addr_1;
  logic [15:0]      cpu_data_0;
  logic [15:0]      cpu_data_1;

  // VPU scalar write offer
  logic             vpu_wr_valid;
  logic             vpu_wr_ready;
  logic [4:0]       vpu_wr_addr;
  logic [15:0]      vpu_wr_data;

  // Register file write ports
  logic             rf_we_0;
  logic             rf_we_1;
  logic [4:0]       rf_addr_0;
  logic [4:0]       rf_addr_1;
  logic [15:0]      rf_data_0;
  logic [15:0]      rf_data_1;

  // Status towards decode / pipeline control
  logic [31:0]      vpu_pend_mask;
  logic [CNT_W-1:0] fifo_count;
  logic             wb_stall_req;
  logic             err_collision;

  modport slave (
    input  cpu_we_0, cpu_we_1, cpu_addr_0, cpu_addr_1, cpu_data_0, cpu_data_1,
    input  vpu_wr_valid, vpu_wr_addr, vpu_wr_data,
    output vpu_wr_ready,
    output rf_we_0, rf_we_1, rf_addr_0, rf_addr_1, rf_data_0, rf_data_1,
    output vpu_pend_mask, fifo_count, wb_stall_req, err_collision
  );

  modport master (
    output cpu_we_0, cpu_we_1, cpu_addr_0, cpu_addr_1, cpu_data_0, cpu_data_1,
    output vpu_wr_valid, vpu_wr_addr, vpu_wr_data,
    input  vpu_wr_ready,
    input  rf_we_0, rf_we_1, rf_addr_0, rf_addr_1, rf_data_0, rf_data_1,
    input  vpu_pend_mask, fifo_count, wb_stall_req, err_collision
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the two register-file write ports between the CPU writeback stage
// (zero-latency pass-through) and VPU scalar results, which are buffered in a
// small FIFO and retired through whichever port the CPU leaves idle.
// Optional feature macro: WB_ARB_STARVE_EN -- when defined, a starvation
// counter on the FIFO head raises wb_stall_req after STARVE_LIMIT waiting
// cycles; when undefined wb_stall_req is tied low and the head waits forever.

module regfile_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,  // power of two, >= 2
  parameter int STARVE_LIMIT = 8   // 1..255
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // FIFO storage; read combinationally at the head, so kept in registers
  logic [4:0]       addr_mem [FIFO_DEPTH];
  logic [15:0]      data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             err_q,    err_d;

  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             collide_0;
  logic             collide_1;
  logic             collision;
  logic             vpu_issue;
  logic             vpu_port0;
  logic             vpu_port1;
  logic [4:0]       head_addr;
  logic [15:0]      head_data;

  logic [FIFO_DEPTH-1:0] slot_valid;
  logic [31:0]           slot_onehot [FIFO_DEPTH];
  logic [31:0]           pend_mask;

  // ---------------------------------------------------------------------
  // Push / head / arbitration decisions
  // ---------------------------------------------------------------------
  assign fifo_empty       = (count_q == '0);
  assign head_addr        = addr_mem[rd_ptr_q];
  assign head_data        = data_mem[rd_ptr_q];

  // Ready depends only on registered occupancy, never on this cycle's inputs
  assign bus.vpu_wr_ready = (count_q != FULL_CNT);
  assign push             = bus.vpu_wr_valid && bus.vpu_wr_ready;

  // A CPU write to the head's destination supersedes the buffered value
  assign collide_0 = !fifo_empty && bus.cpu_we_0 && (bus.cpu_addr_0 == head_addr);
  assign collide_1 = !fifo_empty && bus.cpu_we_1 && (bus.cpu_addr_1 == head_addr);
  assign collision = collide_0 || collide_1;

  // Head issues into port 0 if idle, else port 1 if idle; collision wins
  assign vpu_issue = !fifo_empty && !collision && (!bus.cpu_we_0 || !bus.cpu_we_1);
  assign vpu_port0 = vpu_issue && !bus.cpu_we_0;
  assign vpu_port1 = vpu_issue &&  bus.cpu_we_0;

  // The head leaves the FIFO either by being written or by being superseded
  assign pop = vpu_issue || collision;

  // ---------------------------------------------------------------------
  // Register-file port muxing
  // ---------------------------------------------------------------------

  // CPU values pass straight through unless the VPU head claims the port
  always_comb begin
    bus.rf_we_0   = bus.cpu_we_0;
    bus.rf_addr_0 = bus.cpu_addr_0;
    bus.rf_data_0 = bus.cpu_data_0;
    bus.rf_we_1   = bus.cpu_we_1;
    bus.rf_addr_1 = bus.cpu_addr_1;
    bus.rf_data_1 = bus.cpu_data_1;
    if (vpu_port0) begin
      bus.rf_we_0   = 1'b1;
      bus.rf_addr_0 = head_addr;
      bus.rf_data_0 = head_data;
    end
    if (vpu_port1) begin
      bus.rf_we_1   = 1'b1;
      bus.rf_addr_1 = head_addr;
      bus.rf_data_1 = head_data;
    end
  end

  // ---------------------------------------------------------------------
  // Pending-destination mask from registered FIFO state
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] slot_ofs;
      // Distance of this slot from the read pointer; valid if inside count
      assign slot_ofs        = PTR_W'(gi) - rd_ptr_q;
      assign slot_valid[gi]  = ({1'b0, slot_ofs} < count_q);
      assign slot_onehot[gi] = slot_valid[gi] ? (32'd1 << addr_mem[gi]) : 32'd0;
    end
  endgenerate

  // OR together the one-hot destinations of all valid entries
  always_comb begin
    pend_mask = 32'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pend_mask = pend_mask | slot_onehot[i];
    end
  end

  assign bus.vpu_pend_mask = pend_mask;
  assign bus.fifo_count    = count_q;
  assign bus.err_collision = err_q;

  // ---------------------------------------------------------------------
  // FIFO pointer, occupancy and error next-state
  // ---------------------------------------------------------------------

  // Pointers wrap naturally because FIFO_DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | collision;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; an asynchronous reset flushes the FIFO at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Entry payload needs no reset: validity comes from the pointers alone
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= bus.vpu_wr_addr;
      data_mem[wr_ptr_q] <= bus.vpu_wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Starvation monitor
  // ---------------------------------------------------------------------
`ifdef WB_ARB_STARVE_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_q, starve_d;

  // Count cycles the head waits; restart on empty or on any pop, saturate
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = 8'd0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 8'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign bus.wb_stall_req = (starve_q == LIMIT);
`else
  assign bus.wb_stall_req = 1'b0;
`endif

endmodule
